ysyx_24110015_lsu: RTL and testbench

YSYX_24110015_LSU -- requirements
Module: ysyx_24110015_lsu

---
 rtl/ysyx_24110015_lsu.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_24110015_lsu.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: captures EXU results, issues one memory request per load/store, hands results to the WBU.
// Optional macro YSYX_24110015_LSU_MISALIGN_CHECK_EN diverts misaligned half/word accesses straight to DONE.
module ysyx_24110015_lsu (
   input  logic         clk,
   input  logic         rst,
   // Every handshake transfers on a rising edge where valid & ready are both 1; valid never drops before that edge.
   input  logic         in_valid,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic [31:0]  pc_i,
   input  logic [31:0]  inst_i,
   input  logic [31:0]  alu_out_i,
   input  logic [31:0]  csr_rdata_i,
   input  logic         RegWrite_i,
   input  logic         zicsr_i,
   input  logic         ebreak_i,
   input  logic         MemRead_i,
   input  logic         MemWrite_i,
   input  logic [4:0]   wb_addr_i,
   input  logic [2:0]   func3_i,
   input  logic [31:0]  store_data_i,
   input  logic [131:0] csr_bus_i,
   output logic [31:0]  pc_o,
   output logic [31:0]  inst_o,
   output logic [31:0]  alu_out_o,
   output logic [31:0]  csr_rdata_o,
   output logic         RegWrite_o,
   output logic         zicsr_o,
   output logic         ebreak_o,
   output logic         MemRead_o,
   output logic [4:0]   wb_addr_o,
   output logic [2:0]   func3_o,
   output logic [131:0] csr_bus_o,
   output logic [31:0]  mem_rdata_o,
   output logic         mem_req_valid,
   input  logic         mem_req_ready,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   output logic         mem_wen,
   output logic [3:0]   mem_wmask,
   input  logic         mem_resp_valid,
   input  logic [31:0]  mem_rdata,
   output logic         processing,
   output logic         misalign_o,
   output logic [1:0]   state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_q;
   logic           out_valid_q, req_valid_q, processing_q;
   logic [31:0]    pc_q, inst_q, alu_q, csr_rdata_q, store_data_q, rdata_q;
   logic           regwrite_q, zicsr_q, ebreak_q, memread_q, memwrite_q;
   logic [4:0]     wb_addr_q;
   logic [2:0]     func3_q;
   logic [131:0]   csr_bus_q;
   logic           misalign_d;
   logic [3:0]     wmask_d;
   logic [31:0]    wdata_d;

`ifdef YSYX_24110015_LSU_MISALIGN_CHECK_EN
   logic misalign_q;

   assign misalign_d = (MemRead_i | MemWrite_i) &&
                       (((func3_i[1:0] == 2'b01) && alu_out_i[0]) ||
                        ((func3_i[1:0] == 2'b10) && (alu_out_i[1:0] != 2'b00)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         misalign_q <= 1'b0;
      else if (in_valid && in_ready)   misalign_q <= misalign_d;
   end

   assign misalign_o = misalign_q;
`else
   assign misalign_d = 1'b0;
   assign misalign_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         out_valid_q  <= 1'b0;
         req_valid_q  <= 1'b0;
         processing_q <= 1'b0;
         pc_q         <= '0;
         inst_q       <= '0;
         alu_q        <= '0;
         csr_rdata_q  <= '0;
         store_data_q <= '0;
         rdata_q      <= '0;
         regwrite_q   <= 1'b0;
         zicsr_q      <= 1'b0;
         ebreak_q     <= 1'b0;
         memread_q    <= 1'b0;
         memwrite_q   <= 1'b0;
         wb_addr_q    <= '0;
         func3_q      <= '0;
         csr_bus_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               pc_q         <= pc_i;
               inst_q       <= inst_i;
               alu_q        <= alu_out_i;
               csr_rdata_q  <= csr_rdata_i;
               store_data_q <= store_data_i;
               rdata_q      <= '0;
               regwrite_q   <= RegWrite_i & ~misalign_d;
               zicsr_q      <= zicsr_i;
               ebreak_q     <= ebreak_i;
               memread_q    <= MemRead_i;
               memwrite_q   <= MemWrite_i;
               wb_addr_q    <= wb_addr_i;
               func3_q      <= func3_i;
               csr_bus_q    <= csr_bus_i;
               processing_q <= 1'b1;
               if ((MemRead_i || MemWrite_i) && !misalign_d) begin
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
               end else begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
               end
            end
            S_REQ: if (mem_req_ready) begin
               req_valid_q <= 1'b0;
               state_q     <= S_WAIT;
            end
            // Responses are only looked at here, so one coinciding with the request handshake is dropped.
            S_WAIT: if (mem_resp_valid) begin
               if (memread_q) rdata_q <= mem_rdata >> {alu_q[1:0], 3'b000};
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: if (out_ready) begin
               out_valid_q  <= 1'b0;
               processing_q <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      wmask_d = 4'b0000;
      wdata_d = store_data_q;
      if (memwrite_q) begin
         case (func3_q)
            3'b000: begin
               wmask_d = 4'b0001 << alu_q[1:0];
               wdata_d = {4{store_data_q[7:0]}};
            end
            3'b001: begin
               wmask_d = 4'b0011 << alu_q[1:0];
               wdata_d = {2{store_data_q[15:0]}};
            end
            3'b010:  wmask_d = 4'b1111;
            default: wmask_d = 4'b0000;
         endcase
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign out_valid     = out_valid_q;
   assign mem_req_valid = req_valid_q;
   assign processing    = processing_q;
   assign state_o       = state_q;
   assign mem_addr      = {alu_q[31:2], 2'b00};
   assign mem_wdata     = wdata_d;
   assign mem_wmask     = wmask_d;
   assign mem_wen       = memwrite_q;
   assign pc_o          = pc_q;
   assign inst_o        = inst_q;
   assign alu_out_o     = alu_q;
   assign csr_rdata_o   = csr_rdata_q;
   assign RegWrite_o    = regwrite_q;
   assign zicsr_o       = zicsr_q;
   assign ebreak_o      = ebreak_q;
   assign MemRead_o     = memread_q;
   assign wb_addr_o     = wb_addr_q;
   assign func3_o       = func3_q;
   assign csr_bus_o     = csr_bus_q;
   assign mem_rdata_o   = rdata_q;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Self-checking bench for ysyx_24110015_lsu: scoreboard of expected WBU results plus a small word memory.
module tb_ysyx_24110015_lsu;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [31:0]  pc_i, inst_i, alu_out_i, csr_rdata_i, store_data_i;
   logic         RegWrite_i, zicsr_i, ebreak_i, MemRead_i, MemWrite_i;
   logic [4:0]   wb_addr_i;
   logic [2:0]   func3_i;
   logic [131:0] csr_bus_i;
   logic [31:0]  pc_o, inst_o, alu_out_o, csr_rdata_o, mem_rdata_o;
   logic         RegWrite_o, zicsr_o, ebreak_o, MemRead_o;
   logic [4:0]   wb_addr_o;
   logic [2:0]   func3_o;
   logic [131:0] csr_bus_o;
   logic         mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0]  mem_addr, mem_wdata, mem_rdata;
   logic [3:0]   mem_wmask;
   logic         processing, misalign_o;
   logic [1:0]   state_o;

   ysyx_24110015_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .pc_i(pc_i), .inst_i(inst_i), .alu_out_i(alu_out_i), .csr_rdata_i(csr_rdata_i),
      .RegWrite_i(RegWrite_i), .zicsr_i(zicsr_i), .ebreak_i(ebreak_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .wb_addr_i(wb_addr_i), .func3_i(func3_i), .store_data_i(store_data_i), .csr_bus_i(csr_bus_i),
      .pc_o(pc_o), .inst_o(inst_o), .alu_out_o(alu_out_o), .csr_rdata_o(csr_rdata_o),
      .RegWrite_o(RegWrite_o), .zicsr_o(zicsr_o), .ebreak_o(ebreak_o), .MemRead_o(MemRead_o),
      .wb_addr_o(wb_addr_o), .func3_o(func3_o), .csr_bus_o(csr_bus_o), .mem_rdata_o(mem_rdata_o),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .processing(processing), .misalign_o(misalign_o), .state_o(state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0]  pc, inst, alu, csr_rdata, sdata;
      logic         regwrite, zicsr, ebreak, memread, memwrite;
      logic [4:0]   wb;
      logic [2:0]   f3;
      logic [131:0] csr_bus;
   } txn_t;

   typedef struct {
      logic [31:0]  pc, inst, alu, csr_rdata, rdata;
      logic [11:0]  ctrl;
      logic [131:0] csr_bus;
      logic         misalign;
      int           lat;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   int          acc_cyc = 0;
   int          first_cyc = 0;
   bit          seen_valid = 0;
   logic [31:0] mem_m [16];
   logic [31:0] rd_word;
   logic        exp_req, exp_wen, hold_resp, spur_en;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wmask;

   task automatic check(input string tag, input logic [131:0] act, input logic [131:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   always begin
      @(negedge clk);
      if (!rst && mem_req_valid && !exp_req) check("unexp_req", mem_req_valid, exp_req);
      if (!rst && mem_req_valid && mem_req_ready && exp_req) begin
         check("mem_addr", mem_addr, exp_addr);
         check("mem_wen", mem_wen, exp_wen);
         check("mem_wmask", mem_wmask, exp_wmask);
         if (exp_wen) check("mem_wdata", mem_wdata, exp_wdata);
         exp_req = 1'b0;
         rd_word = mem_m[exp_addr[5:2]];
         for (int b = 0; b < 4; b++)
            if (exp_wmask[b]) mem_m[exp_addr[5:2]][8*b +: 8] = exp_wdata[8*b +: 8];
         if (spur_en) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hDEAD_BEEF;
         end
         @(posedge clk); #1;
         if (hold_resp) begin
            mem_resp_valid = 1'b0;
            @(posedge clk); #1;
         end
         mem_resp_valid = 1'b1;
         mem_rdata      = rd_word;
         @(posedge clk); #1;
         mem_resp_valid = 1'b0;
         mem_rdata      = 32'h0BAD_F00D;
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !seen_valid) begin
            seen_valid = 1;
            first_cyc  = cyc;
         end
         if (out_valid && out_ready) begin
            seen_valid = 0;
            if (exp_q.size() == 0) check("sb_empty", out_valid, 1'b0);
            else begin
               mon_e = exp_q.pop_front();
               check("pc_o", pc_o, mon_e.pc);
               check("inst_o", inst_o, mon_e.inst);
               check("alu_out_o", alu_out_o, mon_e.alu);
               check("csr_rdata_o", csr_rdata_o, mon_e.csr_rdata);
               check("ctrl_o", {RegWrite_o, zicsr_o, ebreak_o, MemRead_o, wb_addr_o, func3_o}, mon_e.ctrl);
               check("csr_bus_o", csr_bus_o, mon_e.csr_bus);
               check("mem_rdata_o", mem_rdata_o, mon_e.rdata);
               check("misalign_o", misalign_o, mon_e.misalign);
               check("in_ready_done", in_ready, 1'b0);
               check("processing_done", processing, 1'b1);
               if (mon_e.lat > 0) check("latency", first_cyc - acc_cyc + 1, mon_e.lat);
            end
            done_cnt++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic txn_t mk_txn(input logic [31:0] alu, input logic rd, input logic wr,
                                   input logic rw, input logic [2:0] f3, input logic [31:0] sd);
      txn_t t;
      t.pc = $urandom; t.inst = $urandom; t.csr_rdata = $urandom;
      t.alu = alu; t.memread = rd; t.memwrite = wr; t.regwrite = rw;
      t.zicsr = 1'($urandom_range(0, 1)); t.ebreak = 1'($urandom_range(0, 1));
      t.wb = 5'($urandom_range(0, 31)); t.f3 = f3; t.sdata = sd;
      t.csr_bus = {4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom};
      return t;
   endfunction

   task automatic start_txn(input txn_t t, input bit chk_lat);
      exp_t       e;
      logic [1:0] a;
      logic       memop, mis;
      bit         ok;
      a     = t.alu[1:0];
      memop = t.memread | t.memwrite;
      mis   = 1'b0;
`ifdef YSYX_24110015_LSU_MISALIGN_CHECK_EN
      mis = memop && ((t.f3[1:0] == 2'b01 && a[0]) || (t.f3[1:0] == 2'b10 && a != 2'b00));
`endif
      e.pc = t.pc; e.inst = t.inst; e.alu = t.alu; e.csr_rdata = t.csr_rdata;
      e.csr_bus  = t.csr_bus;
      e.ctrl     = {t.regwrite & ~mis, t.zicsr, t.ebreak, t.memread, t.wb, t.f3};
      e.rdata    = (t.memread && !mis) ? (mem_m[t.alu[5:2]] >> (8 * a)) : 32'h0;
      e.misalign = mis;
      e.lat      = chk_lat ? ((memop && !mis) ? 3 : 1) : 0;
      exp_q.push_back(e);
      exp_addr  = {t.alu[31:2], 2'b00};
      exp_wen   = t.memwrite;
      exp_wdata = t.sdata;
      exp_wmask = 4'b0000;
      if (t.memwrite) begin
         if (t.f3 == 3'b000) begin
            exp_wmask = 4'b0001 << a;
            exp_wdata = {t.sdata[7:0], t.sdata[7:0], t.sdata[7:0], t.sdata[7:0]};
         end else if (t.f3 == 3'b001) begin
            exp_wmask = 4'b0011 << a;
            exp_wdata = {t.sdata[15:0], t.sdata[15:0]};
         end else if (t.f3 == 3'b010) exp_wmask = 4'b1111;
      end
      exp_req = memop && !mis;
      @(posedge clk); #1;
      pc_i = t.pc; inst_i = t.inst; alu_out_i = t.alu; csr_rdata_i = t.csr_rdata;
      RegWrite_i = t.regwrite; zicsr_i = t.zicsr; ebreak_i = t.ebreak;
      MemRead_i = t.memread; MemWrite_i = t.memwrite;
      wb_addr_i = t.wb; func3_i = t.f3; store_data_i = t.sdata; csr_bus_i = t.csr_bus;
      in_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) check("accept", in_ready, 1'b1);
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int target;
      bit ok;
      target = done_cnt + 1;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done_cnt >= target) begin ok = 1; break; end
      end
      check("done", ok, 1'b1);
      check("req_issued", exp_req, 1'b0);
   endtask

   task automatic run_txn(input txn_t t);
      start_txn(t, 1'b1);
      wait_done();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      txn_t t;
      logic [2:0] ld_f3 [5];
      bit ok;
      int k;
      ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
      rst = 1'b1;
      in_valid = 0; out_ready = 1; mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = 32'h0BAD_F00D;
      pc_i = 0; inst_i = 0; alu_out_i = 0; csr_rdata_i = 0; store_data_i = 0; csr_bus_i = '0;
      RegWrite_i = 0; zicsr_i = 0; ebreak_i = 0; MemRead_i = 0; MemWrite_i = 0; wb_addr_i = 0; func3_i = 0;
      exp_req = 0; exp_wen = 0; exp_addr = 0; exp_wdata = 0; exp_wmask = 0; hold_resp = 0; spur_en = 0;
      for (int i = 0; i < 16; i++) mem_m[i] = 32'h1357_9BDF ^ (32'h0101_0101 * i);
      mem_m[0] = 32'hAABB_CCDD;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_processing", processing, 1'b0);
      check("rst_misalign", misalign_o, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_state", state_o, 2'd0);
      check("rst_data", {pc_o, alu_out_o, mem_rdata_o, RegWrite_o, MemRead_o}, '0);
      rst = 1'b0;

      // ALU op, lb, sh, lw read-back
      run_txn(mk_txn(32'h0000_1234, 0, 0, 1, 3'b000, 32'h0));
      run_txn(mk_txn(32'h8000_0003, 1, 0, 1, 3'b000, 32'h0));
      run_txn(mk_txn(32'h8000_0002, 0, 1, 0, 3'b001, 32'h0000_BEEF));
      check("sh_mem", mem_m[0], 32'hBEEF_CCDD);
      run_txn(mk_txn(32'h8000_0000, 1, 0, 1, 3'b010, 32'h0));

      // response coinciding with the request handshake must be ignored
      spur_en = 1;
      run_txn(mk_txn(32'h8000_0004, 1, 0, 1, 3'b010, 32'h0));
      spur_en = 0;

      // lw at a misaligned address
      run_txn(mk_txn(32'h8000_0002, 1, 0, 1, 3'b010, 32'h0));

      // memory and WBU back-pressure
      mem_req_ready = 0;
      out_ready = 0;
      start_txn(mk_txn(32'h8000_0008, 0, 1, 0, 3'b010, 32'hCAFE_F00D), 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_req_valid", mem_req_valid, 1'b1);
         check("stall_addr", mem_addr, 32'h8000_0008);
         check("stall_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      mem_req_ready = 1;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      check("stall_done_reach", ok, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check("hold_out_valid", out_valid, 1'b1);
         check("hold_alu_out", alu_out_o, 32'h8000_0008);
         check("hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1;
      wait_done();
      check("sw_mem", mem_m[2], 32'hCAFE_F00D);

      // reset while waiting for a response, late response afterwards
      hold_resp = 1;
      start_txn(mk_txn(32'h8000_0000, 1, 0, 1, 3'b010, 32'h0), 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("wait_state", state_o, 2'd2);
      #1 rst = 1'b1;
      #1;
      check("arst_state", state_o, 2'd0);
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_processing", processing, 1'b0);
      check("arst_data", {pc_o, alu_out_o, RegWrite_o}, '0);
      #1 rst = 1'b0;
      exp_q.delete();
      exp_req = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_out_valid", out_valid, 1'b0);
         check("post_rst_state", state_o, 2'd0);
      end
      hold_resp = 0;
      run_txn(mk_txn(32'h0000_5678, 0, 0, 1, 3'b000, 32'h0));

      // random mix
      for (int n = 0; n < 16; n++) begin
         k = $urandom_range(0, 2);
         if (k == 0)
            t = mk_txn($urandom, 0, 0, 1, 3'($urandom_range(0, 7)), $urandom);
         else if (k == 1)
            t = mk_txn(32'h8000_0000 | 32'($urandom_range(0, 63)), 1, 0, 1, ld_f3[$urandom_range(0, 4)], $urandom);
         else
            t = mk_txn(32'h8000_0000 | 32'($urandom_range(0, 63)), 0, 1, 0, 3'($urandom_range(0, 2)), $urandom);
         run_txn(t);
      end

      repeat (2) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
